// File: rtl/pulse_interval_meter.sv
// Coarse start-to-stop interval meter: counts clock cycles between a start edge
// and a stop edge (or a timeout) and hands each result out over valid/ready.
module pulse_interval_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic             result_ready,
  output logic             result_valid,
  output logic [WIDTH-1:0] interval,
  output logic             timeout,
  output logic             busy,
  output logic [15:0]      missed_cnt
);

  localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic             start_q;
  logic             stop_q;
  logic [WIDTH-1:0] cnt;
  logic             start_edge;
  logic             stop_edge;

  // A level held high yields one edge, so long pulses count as a single event.
  assign start_edge = start_in & ~start_q;
  assign stop_edge  = stop_in  & ~stop_q;

  // NOTE: state is updated with non-blocking assignments so every register in
  // this block sees the pre-edge values of its neighbours, like real flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      cnt          <= '0;
      result_valid <= 1'b0;
      interval     <= '0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
      missed_cnt   <= '0;
    end else begin
      start_q <= start_in;
      stop_q  <= stop_in;

      // Starts that arrive while a measurement or result is pending are dropped.
      if (start_edge && (state != IDLE) && (missed_cnt != 16'hFFFF))
        missed_cnt <= missed_cnt + 16'd1;

      unique case (state)
        IDLE: begin
          if (start_edge && stop_edge) begin
            state        <= DONE;
            interval     <= '0;
            timeout      <= 1'b0;
            result_valid <= 1'b1;
          end else if (start_edge) begin
            state <= MEASURE;
            cnt   <= WIDTH'(1);
            busy  <= 1'b1;
          end
        end

        MEASURE: begin
          if (stop_edge) begin
            state        <= DONE;
            interval     <= cnt;
            timeout      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end else if (cnt == TIMEOUT_CNT) begin
            state        <= DONE;
            interval     <= TIMEOUT_CNT;
            timeout      <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end

        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Scoreboard bench for pulse_interval_meter with a short TIMEOUT of 20 cycles.
module tb_pulse_interval_meter;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned TIMEOUT = 20;

  typedef struct {
    longint interval;
    longint timeout;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_in;
  logic             stop_in;
  logic             result_ready;
  logic             result_valid;
  logic [WIDTH-1:0] interval;
  logic             timeout;
  logic             busy;
  logic [15:0]      missed_cnt;

  int     checks   = 0;
  int     failures = 0;
  int     exp_missed = 0;
  exp_t   sb[$];

  pulse_interval_meter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_in     (start_in),
    .stop_in      (stop_in),
    .result_ready (result_ready),
    .result_valid (result_valid),
    .interval     (interval),
    .timeout      (timeout),
    .busy         (busy),
    .missed_cnt   (missed_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge, well clear of sampling.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic exp_t mk(input longint iv, input longint to);
    exp_t e;
    e.interval = iv;
    e.timeout  = to;
    return e;
  endfunction

  // A transfer happens at the next rising edge whenever valid and ready are
  // both high mid-cycle; that is where results are scored.
  always @(negedge clk) begin
    if (reset && result_valid && result_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_interval", longint'(interval), e.interval);
        check("sb_timeout",  longint'(timeout),  e.timeout);
      end
    end
  end

  initial begin
    int n;
    int bcnt;

    reset        = 1'b0;
    start_in     = 1'b0;
    stop_in      = 1'b0;
    result_ready = 1'b1;
    #23;
    check("rst_valid",    result_valid, 0);
    check("rst_busy",     busy,         0);
    check("rst_interval", interval,     0);
    check("rst_timeout",  timeout,      0);
    check("rst_missed",   missed_cnt,   0);
    @(negedge clk);
    reset = 1'b1;
    step(2);

    // 1: basic spacing of 10 cycles
    start_in = 1'b1;
    step(1);
    start_in = 1'b0;
    check("t1_busy", busy, 1);
    step(9);
    check("t1_valid_early", result_valid, 0);
    stop_in = 1'b1;
    sb.push_back(mk(10, 0));
    step(1);
    stop_in = 1'b0;
    check("t1_valid", result_valid, 1);
    check("t1_busy_done", busy, 0);
    step(1);
    check("t1_valid_drop", result_valid, 0);

    // 2: coincident start and stop from IDLE, then a lone stop
    step(1);
    start_in = 1'b1;
    stop_in  = 1'b1;
    sb.push_back(mk(0, 0));
    step(1);
    start_in = 1'b0;
    stop_in  = 1'b0;
    check("t2_valid", result_valid, 1);
    check("t2_busy", busy, 0);
    step(1);
    check("t2_valid_drop", result_valid, 0);
    step(1);
    stop_in = 1'b1;
    step(1);
    stop_in = 1'b0;
    step(3);
    check("t2_stray_valid", result_valid, 0);
    check("t2_stray_busy", busy, 0);

    // 3: timeout with no stop
    start_in = 1'b1;
    sb.push_back(mk(TIMEOUT, 1));
    n    = 0;
    bcnt = 0;
    do begin
      step(1);
      start_in = 1'b0;
      n++;
      if (busy) bcnt++;
    end while (!result_valid && n < 100);
    check("t3_latency", n, TIMEOUT + 1);
    check("t3_busy_cycles", bcnt, TIMEOUT);
    check("t3_timeout_flag", timeout, 1);
    step(1);
    check("t3_valid_drop", result_valid, 0);
    step(1);

    // 4: backpressure with two starts during the wait, third on transfer cycle
    result_ready = 1'b0;
    start_in = 1'b1;
    step(1);
    start_in = 1'b0;
    step(6);
    stop_in = 1'b1;
    sb.push_back(mk(7, 0));
    step(1);
    stop_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t4_hold_valid", result_valid, 1);
      check("t4_hold_interval", interval, 7);
      start_in = (i == 2 || i == 5);
      step(1);
    end
    start_in = 1'b0;
    exp_missed += 2;
    check("t4_missed", missed_cnt, exp_missed);
    step(1);
    result_ready = 1'b1;
    start_in     = 1'b1;
    step(1);
    start_in = 1'b0;
    exp_missed += 1;
    check("t4_after_valid", result_valid, 0);
    check("t4_after_busy", busy, 0);
    check("t4_missed_xfer", missed_cnt, exp_missed);
    step(2);
    check("t4_idle_busy", busy, 0);

    // 5a: long start (4 cycles), extra start mid-measure, long stop at +12
    start_in = 1'b1;
    step(4);
    start_in = 1'b0;
    step(2);
    start_in = 1'b1;
    step(1);
    start_in = 1'b0;
    exp_missed += 1;
    step(5);
    stop_in = 1'b1;
    sb.push_back(mk(12, 0));
    step(1);
    check("t5_valid", result_valid, 1);
    step(2);
    stop_in = 1'b0;
    check("t5_valid_drop", result_valid, 0);
    check("t5_missed", missed_cnt, exp_missed);
    step(2);

    // 5b: asynchronous reset in the middle of a measurement
    start_in = 1'b1;
    step(1);
    start_in = 1'b0;
    step(5);
    check("t5_busy_before_rst", busy, 1);
    #2;
    reset = 1'b0;
    exp_missed = 0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_valid", result_valid, 0);
    check("t5_rst_missed", missed_cnt, exp_missed);
    step(1);
    reset = 1'b1;
    step(2);
    start_in = 1'b1;
    step(1);
    start_in = 1'b0;
    step(2);
    stop_in = 1'b1;
    sb.push_back(mk(3, 0));
    step(1);
    stop_in = 1'b0;
    check("t5_post_valid", result_valid, 1);
    step(2);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
